// File: rtl/e203_itcm_ram_ctrl_pkg.sv
// Shared types and defaults for the ITCM RAM controller.
// RAM geometry defaults come from the E203_ITCM_RAM_* macros of e203_defines.v when it is compiled first.
`ifndef E203_ITCM_RAM_DP
  `define E203_ITCM_RAM_DP 8192
`endif
`ifndef E203_ITCM_RAM_DW
  `define E203_ITCM_RAM_DW 64
`endif
`ifndef E203_ITCM_RAM_MW
  `define E203_ITCM_RAM_MW 8
`endif
`ifndef E203_ITCM_RAM_AW
  `define E203_ITCM_RAM_AW 13
`endif

package e203_itcm_ram_ctrl_pkg;

  localparam int ITCM_RAM_DP = `E203_ITCM_RAM_DP;
  localparam int ITCM_RAM_DW = `E203_ITCM_RAM_DW;
  localparam int ITCM_RAM_MW = `E203_ITCM_RAM_MW;
  localparam int ITCM_RAM_AW = `E203_ITCM_RAM_AW;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_SLEEP  = 2'd1,
    PWR_WAKE   = 2'd2
  } pwr_state_e;

  // Responses held in the buffer plus the one command still waiting for RAM data.
  function automatic logic [1:0] occupancy(input logic [1:0] buf_cnt, input logic infl_vld);
    return buf_cnt + {1'b0, infl_vld};
  endfunction

endpackage

// File: rtl/e203_itcm_ram_ctrl_rspbuf.sv
// Two-entry response FIFO; the head entry is presented combinationally and
// stays stable until popped.
module e203_itcm_ram_ctrl_rspbuf
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [0:1];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_push_s = push & (cnt_r != 2'd2);
  assign do_pop_s  = pop & (cnt_r != 2'd0);
  assign count     = cnt_r;

  // Storage; contents are meaningless while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Head entry, forced to zero when empty.
  always_comb begin
    pop_data = '0;
    if (cnt_r != 2'd0) begin
      pop_data = mem_r[rd_ptr_r];
    end else begin
      pop_data = '0;
    end
  end

endmodule

// File: rtl/e203_itcm_ram_ctrl.sv
// ICB-to-SRAM bridge for the ITCM: range check, one-cycle RAM pipeline,
// two-entry response buffer and idle-driven light-sleep control.
module e203_itcm_ram_ctrl
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int DP      = ITCM_RAM_DP,
  parameter int DW      = ITCM_RAM_DW,
  parameter int MW      = ITCM_RAM_MW,
  parameter int AW      = ITCM_RAM_AW,
  parameter int ADDR_W  = 17,
  parameter int LS_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [MW-1:0]     icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_ls,
  output logic              ram_ds,
  output logic              ram_sd
);

  localparam int BSH   = $clog2(MW);
  localparam int IDX_W = ADDR_W - BSH;
  localparam int CNT_W = $clog2(LS_IDLE + 2);

  pwr_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  idle_cnt_r, idle_cnt_nxt_s;
  logic              infl_vld_r, infl_read_r, infl_err_r;
  logic [IDX_W-1:0]  idx_s;
  logic              in_range_s;
  logic              accept_s;
  logic [1:0]        buf_cnt_s;
  logic [1:0]        occ_s;
  logic              buf_valid_s;
  logic              rsp_pop_s;
  logic [DW:0]       push_data_s;
  logic [DW:0]       head_s;
  logic              unused_addr_s;

  assign idx_s         = icb_cmd_addr[ADDR_W-1:BSH];
  assign unused_addr_s = ^icb_cmd_addr[BSH-1:0];
  assign in_range_s    = ({1'b0, idx_s} < (IDX_W+1)'(DP));

  assign occ_s       = occupancy(buf_cnt_s, infl_vld_r);
  assign buf_valid_s = (buf_cnt_s != 2'd0);
  assign rsp_pop_s   = buf_valid_s & icb_rsp_ready;

  // A pop in the same cycle frees a slot, which keeps full throughput at occupancy 2.
  assign icb_cmd_ready = ~rst & (state_r == PWR_ACTIVE) & ((occ_s < 2'd2) | rsp_pop_s);
  assign accept_s      = icb_cmd_valid & icb_cmd_ready;

  assign icb_rsp_valid = ~rst & buf_valid_s;
  assign icb_rsp_err   = ~rst & buf_valid_s & head_s[DW];
  assign icb_rsp_rdata = (~rst & buf_valid_s) ? head_s[DW-1:0] : '0;

  assign ram_ls = ~rst & (state_r == PWR_SLEEP);
  assign ram_ds = 1'b0;
  assign ram_sd = 1'b0;

  // RAM strobes follow the accepted command in the same cycle.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (accept_s & in_range_s) begin
      ram_cs   = 1'b1;
      ram_we   = ~icb_cmd_read;
      ram_addr = idx_s[AW-1:0];
      ram_wem  = icb_cmd_read ? '0 : icb_cmd_wmask;
      ram_din  = icb_cmd_wdata;
    end else begin
      ram_cs   = 1'b0;
    end
  end

  // Only an in-range read carries RAM data into the response.
  always_comb begin
    push_data_s = '0;
    if (infl_read_r & ~infl_err_r) begin
      push_data_s = {1'b0, ram_dout};
    end else begin
      push_data_s = {infl_err_r, {DW{1'b0}}};
    end
  end

  // Power state and idle counter next-state.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = '0;
    case (state_r)
      PWR_ACTIVE: begin
        if (~accept_s && (occ_s == 2'd0)) begin
          idle_cnt_nxt_s = (idle_cnt_r == CNT_W'(LS_IDLE)) ? idle_cnt_r : idle_cnt_r + 1'b1;
        end else begin
          idle_cnt_nxt_s = '0;
        end
        if ((LS_IDLE != 0) && (idle_cnt_r == CNT_W'(LS_IDLE)) && ~accept_s && (occ_s == 2'd0)) begin
          state_nxt_s = PWR_SLEEP;
        end else begin
          state_nxt_s = PWR_ACTIVE;
        end
      end
      PWR_SLEEP: begin
        if (icb_cmd_valid) begin
          state_nxt_s = PWR_WAKE;
        end else begin
          state_nxt_s = PWR_SLEEP;
        end
      end
      PWR_WAKE: state_nxt_s = PWR_ACTIVE;
      default:  state_nxt_s = PWR_ACTIVE;
    endcase
  end

  // State, idle counter and the in-flight stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PWR_ACTIVE;
      idle_cnt_r  <= '0;
      infl_vld_r  <= 1'b0;
      infl_read_r <= 1'b0;
      infl_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idle_cnt_r  <= idle_cnt_nxt_s;
      infl_vld_r  <= accept_s;
      infl_read_r <= icb_cmd_read;
      infl_err_r  <= ~in_range_s;
    end
  end

  e203_itcm_ram_ctrl_rspbuf #(
    .W (DW + 1)
  ) u_rspbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_vld_r),
    .push_data (push_data_s),
    .pop       (rsp_pop_s),
    .pop_data  (head_s),
    .count     (buf_cnt_s)
  );

endmodule

// File: tb/tb_e203_itcm_ram_ctrl.sv
// Directed self-checking bench for e203_itcm_ram_ctrl with a behavioural
// single-port RAM model.
module tb_e203_itcm_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [16:0] icb_cmd_addr;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [63:0] icb_rsp_rdata;
  logic        ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;

  logic [63:0] mem [0:8191];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] rd_q [$];
  logic        er_q [$];
  int          cy_q [$];

  always #5 clk = ~clk;

  e203_itcm_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls),
    .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++) begin
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && icb_rsp_valid && icb_rsp_ready) begin
      rd_q.push_back(icb_rsp_rdata);
      er_q.push_back(icb_rsp_err);
      cy_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i + 1);
  endfunction

  task automatic send(input logic rd, input logic [16:0] addr, input logic [63:0] wd,
                      input logic [7:0] wm, input logic exp_cs, input string tag,
                      output int acc_cyc);
    int n;
    n = 0;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd;   icb_cmd_wmask = wm;
    @(negedge clk);
    while (!icb_cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_ready"}, 64'(icb_cmd_ready), 64'd1);
    check({tag, "_cs"}, 64'(ram_cs), 64'(exp_cs));
    if (exp_cs) begin
      check({tag, "_ram"}, {42'd0, ram_we, ram_addr, ram_wem}, {42'd0, ~rd, addr[15:3], rd ? 8'h00 : wm});
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [63:0] exp_d, input logic exp_e, input int acc_cyc,
                         input string tag, output int pop_cyc);
    int n;
    n = 0;
    pop_cyc = 0;
    while (rd_q.size() == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rsp_seen"}, 64'(rd_q.size() != 0), 64'd1);
    if (rd_q.size() != 0) begin
      pop_cyc = cy_q.pop_front();
      check({tag, "_rdata"}, rd_q.pop_front(), exp_d);
      check({tag, "_err"}, 64'(er_q.pop_front()), 64'(exp_e));
      check({tag, "_lat"}, 64'(pop_cyc - acc_cyc), 64'd2);
    end
  endtask

  task automatic xfer(input logic rd, input logic [16:0] addr, input logic [63:0] wd,
                      input logic [7:0] wm, input logic exp_cs, input logic [63:0] exp_d,
                      input logic exp_e, input string tag, output int pop_cyc);
    int acc;
    send(rd, addr, wd, wm, exp_cs, tag, acc);
    get_rsp(exp_d, exp_e, acc, tag, pop_cyc);
  endtask

  task automatic wait_rsps(input int cnt);
    int n;
    n = 0;
    while (rd_q.size() < cnt && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_count", 64'(rd_q.size()), 64'(cnt));
  endtask

  initial begin
    int p, acc, idx, n;
    for (int i = 0; i < 8192; i++) mem[i] = 64'd0;
    ram_dout = 64'd0;
    rst = 1'b1; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = 17'd0;
    icb_cmd_wdata = 64'd0; icb_cmd_wmask = 8'd0; icb_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {56'd0, icb_cmd_ready, icb_rsp_valid, icb_rsp_err, ram_cs, ram_we, ram_ls, ram_ds, ram_sd}, 64'd0);
    check("rst_rdata", icb_rsp_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full write then read back
    xfer(1'b0, 17'h00010, 64'h1122334455667788, 8'hFF, 1'b1, 64'd0, 1'b0, "wr_full", p);
    xfer(1'b1, 17'h00010, 64'd0, 8'h00, 1'b1, 64'h1122334455667788, 1'b0, "rd_full", p);
    // Partial mask over zeroed word
    xfer(1'b0, 17'h00020, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1, 64'd0, 1'b0, "wr_half", p);
    xfer(1'b1, 17'h00020, 64'd0, 8'h00, 1'b1, 64'h00000000FFFFFFFF, 1'b0, "rd_half", p);
    // Zero mask is a no-op access
    xfer(1'b0, 17'h00010, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b1, 64'd0, 1'b0, "wr_nomask", p);
    xfer(1'b1, 17'h00010, 64'd0, 8'h00, 1'b1, 64'h1122334455667788, 1'b0, "rd_nomask", p);
    // Last word in range, first word out of range
    xfer(1'b0, 17'h0FFF8, 64'hCAFEF00D12345678, 8'hFF, 1'b1, 64'd0, 1'b0, "wr_last", p);
    xfer(1'b1, 17'h0FFF8, 64'd0, 8'h00, 1'b1, 64'hCAFEF00D12345678, 1'b0, "rd_last", p);
    xfer(1'b1, 17'h10000, 64'd0, 8'h00, 1'b0, 64'd0, 1'b1, "rd_oor", p);
    xfer(1'b0, 17'h10008, 64'h5555555555555555, 8'hFF, 1'b0, 64'd0, 1'b1, "wr_oor", p);
    xfer(1'b1, 17'h00008, 64'd0, 8'h00, 1'b1, 64'd0, 1'b0, "rd_zero", p);

    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 17'h100 + 17'(8 * i), pat(i), 8'hFF, 1'b1, 64'd0, 1'b0, "wr_pat", p);
    end

    // Back-to-back reads with the response side always ready
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 17'h100 + 17'(8 * i);
      @(negedge clk);
      if (icb_cmd_ready) idx++;
      @(posedge clk); #1;
    end
    icb_cmd_valid = 1'b0;
    check("b2b_accepts", 64'(idx), 64'd8);
    wait_rsps(8);
    for (int i = 0; i < 8 && rd_q.size() > 0; i++) begin
      check("b2b_data", rd_q.pop_front(), pat(i));
      check("b2b_err", 64'(er_q.pop_front()), 64'd0);
      void'(cy_q.pop_front());
    end

    // Stalled response side: only two commands fit
    icb_rsp_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 17'h100 + 17'(8 * idx);
      @(negedge clk);
      if (icb_cmd_ready) idx++;
      @(posedge clk); #1;
    end
    check("stall_accepts", 64'(idx), 64'd2);
    @(negedge clk);
    check("stall_hold", {63'd0, icb_rsp_valid}, 64'd1);
    check("stall_hold_data", icb_rsp_rdata, pat(0));
    @(posedge clk); #1;
    icb_rsp_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 17'h100 + 17'(8 * idx);
      @(negedge clk);
      if (icb_cmd_ready) idx++;
      @(posedge clk); #1;
      n++;
    end
    icb_cmd_valid = 1'b0;
    wait_rsps(4);
    for (int i = 0; i < 4 && rd_q.size() > 0; i++) begin
      check("stall_data", rd_q.pop_front(), pat(i));
      void'(er_q.pop_front());
      void'(cy_q.pop_front());
    end

    // Light sleep after 16 idle cycles, then 2-cycle wake
    xfer(1'b1, 17'h00010, 64'd0, 8'h00, 1'b1, 64'h1122334455667788, 1'b0, "pre_sleep", p);
    while (cyc < p + 17) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ls_before", 64'(ram_ls), 64'd0);
    @(negedge clk);
    check("ls_enter", 64'(ram_ls), 64'd1);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 17'h00020;
    idx = cyc;
    @(negedge clk);
    check("ls_wake0", {62'd0, ram_ls, icb_cmd_ready}, 64'd2);
    @(negedge clk);
    check("ls_wake1", {62'd0, ram_ls, icb_cmd_ready}, 64'd0);
    @(posedge clk); #1;
    send(1'b1, 17'h00020, 64'd0, 8'h00, 1'b1, "wake_rd", acc);
    check("wake_penalty", 64'(acc - idx), 64'd2);
    get_rsp(64'h00000000FFFFFFFF, 1'b0, acc, "wake_rd", p);

    // Command on the cycle the idle count saturates wins over sleep
    while (cyc < p + 17) begin
      @(posedge clk); #1;
    end
    send(1'b1, 17'h0FFF8, 64'd0, 8'h00, 1'b1, "edge_rd", acc);
    check("edge_acc_cyc", 64'(acc - p), 64'd17);
    @(negedge clk);
    check("edge_no_sleep", 64'(ram_ls), 64'd0);
    get_rsp(64'hCAFEF00D12345678, 1'b0, acc, "edge_rd", p);

    // Reset with two responses pending
    icb_rsp_ready = 1'b0;
    idx = 0;
    n = 0;
    while (idx < 2 && n < 20) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 17'h00010;
      @(negedge clk);
      if (icb_cmd_ready) idx++;
      @(posedge clk); #1;
      n++;
    end
    icb_cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("pend_full", {62'd0, icb_rsp_valid, icb_cmd_ready}, 64'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", {61'd0, icb_rsp_valid, icb_cmd_ready, ram_cs}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_rsp", 64'(rd_q.size()), 64'd0);
    xfer(1'b1, 17'h00010, 64'd0, 8'h00, 1'b1, 64'h1122334455667788, 1'b0, "post_rst", p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_itcm_ram_ctrl.md
E203_ITCM_RAM_CTRL -- requirements
Module: e203_itcm_ram_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  DP  8192  RAM depth in words
  DW  64  data width, bus and RAM
  MW  8  byte-mask width (DW/8)
  AW  13  RAM word-address width
  ADDR_W  17  bus byte-address width
  LS_IDLE  16  idle cycles before light sleep; 0 disables sleep
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock; all logic rising-edge
  rst  in  1  reset, synchronous, active-high
  icb_cmd_valid  in  1  command valid
  icb_cmd_ready  out  1  command ready
  icb_cmd_read  in  1  1=read, 0=write
  icb_cmd_addr  in  ADDR_W  byte address
  icb_cmd_wdata  in  DW  write data
  icb_cmd_wmask  in  MW  write byte enables
  icb_rsp_valid  out  1  response valid
  icb_rsp_ready  in  1  response ready
  icb_rsp_rdata  out  DW  read data; 0 for writes/errors
  icb_rsp_err  out  1  out-of-range access
  ram_cs, ram_we  out  1  RAM chip select, write enable
  ram_addr  out  AW  RAM word address
  ram_wem  out  MW  RAM byte write mask
  ram_din  out  DW  RAM write data
  ram_dout  in  DW  RAM read data, valid one cycle after read cs
  ram_ls  out  1  RAM light sleep
  ram_ds, ram_sd  out  1  deep sleep / shutdown, constant 0

Function
REQ-003 Command accepted on cycle with icb_cmd_valid & icb_cmd_ready.
REQ-004 Word index = icb_cmd_addr[ADDR_W-1:log2(MW)]; in range iff index < DP.
REQ-005 On accept, in range: ram_cs=1, ram_we=~read, ram_addr=index[AW-1:0], ram_wem=read?0:wmask, ram_din=wdata, combinational same cycle; else ram_cs=0, ram_we=0, ram_wem=0.
REQ-006 Write with wmask 0 SHALL still assert ram_cs (no-op) and return a normal response.
REQ-007 Out-of-range: no RAM access; response err=1, rdata=0.
REQ-008 Accepted command SHALL register an in-flight stage {is_read, err}; next cycle push one entry into 2-entry response buffer: rdata=ram_dout if in-range read, else 0.
REQ-009 Accept at cycle N -> icb_rsp_valid earliest at N+2; responses strictly in command order, one per command.
REQ-010 icb_rsp_valid = buffer non-empty; entry popped on icb_rsp_valid & icb_rsp_ready; rsp outputs held stable while valid & ~ready.
REQ-011 occupancy = buffer count + in-flight; icb_cmd_ready = (state==ACTIVE) & (occupancy<2 | (icb_rsp_valid & icb_rsp_ready)).
REQ-012 With rsp_ready held 1 and cmd_valid held 1, SHALL sustain one command per cycle.
REQ-013 Simultaneous push and pop: count unchanged; buffer never overflows or underflows.
REQ-014 Power FSM states ACTIVE, SLEEP, WAKE; ram_ls=1 only in SLEEP; icb_cmd_ready=0 in SLEEP and WAKE.
REQ-015 Idle counter: increments each ACTIVE cycle with no accept and occupancy 0, saturates at LS_IDLE; clears otherwise.
REQ-016 ACTIVE->SLEEP when counter==LS_IDLE and LS_IDLE!=0; SLEEP->WAKE when icb_cmd_valid=1; WAKE->ACTIVE unconditionally next cycle (wake penalty 2 cycles).
REQ-017 Command arriving in ACTIVE on the cycle counter reaches LS_IDLE SHALL be accepted; transition to SLEEP suppressed.

Reset
REQ-018 While rst=1: icb_cmd_ready=0, icb_rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cs=0, ram_we=0, ram_ls=0, state=ACTIVE, counter=0, buffer and in-flight cleared.
REQ-019 Reset mid-operation SHALL discard in-flight and buffered responses; none emitted after release.

Structure
REQ-020 DP/DW/MW/AW defaults SHALL come from shared E203_ITCM_RAM_* defines in e203_defines.v; FSM encodings local.
REQ-021 Response buffer SHALL be sub-module e203_itcm_ram_ctrl_rspbuf (2-entry FIFO, DW+1 bits).

Verification
REQ-022 Write addr 0x0010 data 0x1122334455667788 mask 0xFF, read 0x0010 -> rdata 0x1122334455667788, err 0, rsp at accept+2.
REQ-023 Write mask 0x0F data all-ones over 0 -> read returns 0x00000000FFFFFFFF.
REQ-024 Read addr 0x10000 -> ram_cs stays 0, rsp err=1, rdata 0.
REQ-025 8 back-to-back reads, rsp_ready=1 -> 8 accepts in 8 cycles, ordered responses; rsp_ready=0 -> ready drops after 2 accepts, no loss.
REQ-026 Idle 16 cycles -> ram_ls=1; cmd_valid -> ram_ls=0 next cycle, accept 2 cycles after valid.
REQ-027 rst pulse with 2 responses pending -> rsp_valid=0 after reset, no stale response.
